// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the instruction-fetch stage.
package fetch_pkg;

    localparam int ADDR_W_DEF         = 32;
    localparam int INSTR_W_DEF        = 32;
    localparam int TIMEOUT_CYCLES_DEF = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Request/acknowledge instruction-memory read bus between fetch and imem.
interface fetch_unit_if
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_timeout_counter.sv
// Saturating wait counter; expired flags the cycle in which the count would reach LIMIT.
module fetch_timeout_counter
    import fetch_pkg::*;
#(
    parameter int LIMIT = TIMEOUT_CYCLES_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Asserted one cycle early so the FSM acts on the same edge the count hits LIMIT.
    assign expired = enable && !clear && (count_q >= CNT_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: reads imem at the current PC and holds the result in the IF/ID register.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int INSTR_W        = INSTR_W_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               fetch_en,
    input  logic [ADDR_W-1:0]  pc,
    input  logic               flush,
    fetch_unit_if.master       imem,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    input  logic               id_ready,
    output logic               pc_advance,
    output logic               fetch_err,
    output logic               align_fault
);
    fetch_state_e       state_q, state_d;
    logic               req_q, req_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  ifpc_q, ifpc_d;
    logic               adv_q, adv_d;
    logic               err_q, err_d;
    logic               align_q, align_d;

    logic tmo_clear, tmo_enable, tmo_expired;
    logic may_start;

    // Faults are sticky and block any further fetch until reset.
    assign may_start = !flush && fetch_en && !err_q && !align_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            instr_q <= '0;
            ifpc_q  <= '0;
            adv_q   <= 1'b0;
            err_q   <= 1'b0;
            align_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
            adv_q   <= adv_d;
            err_q   <= err_d;
            align_q <= align_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (may_start && (pc[1:0] == 2'b00)) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (imem.imem_ack)  state_d = flush ? ST_IDLE : ST_HOLD;
                else if (tmo_expired) state_d = ST_IDLE;
                else if (flush)       state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (imem.imem_ack || tmo_expired) state_d = ST_IDLE;
            end
            ST_HOLD: begin
                if (flush || id_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_d   = req_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        adv_d   = 1'b0;
        err_d   = err_q;
        align_d = align_q;
        unique case (state_q)
            ST_IDLE: begin
                if (may_start) begin
                    if (pc[1:0] != 2'b00) begin
                        align_d = 1'b1;
                    end else begin
                        addr_d = pc;
                        req_d  = 1'b1;
                    end
                end
            end
            ST_REQ, ST_DRAIN: begin
                if (imem.imem_ack) begin
                    req_d = 1'b0;
                    // addr_q doubles as the PC holding register for the in-flight fetch.
                    if ((state_q == ST_REQ) && !flush) begin
                        valid_d = 1'b1;
                        instr_d = imem.imem_rdata;
                        ifpc_d  = addr_q;
                    end
                end else if (tmo_expired) begin
                    req_d = 1'b0;
                    err_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (flush) begin
                    valid_d = 1'b0;
                end else if (id_ready) begin
                    valid_d = 1'b0;
                    adv_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign tmo_clear  = (state_q == ST_IDLE) && (state_d == ST_REQ);
    assign tmo_enable = ((state_q == ST_REQ) || (state_q == ST_DRAIN)) && !imem.imem_ack;

    fetch_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign if_valid       = valid_q;
    assign if_instr       = instr_q;
    assign if_pc          = ifpc_q;
    assign pc_advance     = adv_q;
    assign fetch_err      = err_q;
    assign align_fault    = align_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: handoff, stall, flush, timeout and misalignment scenarios.
module tb_fetch_unit;

    logic        clock;
    logic        reset;
    logic        fetch_en;
    logic [31:0] pc;
    logic        flush;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        pc_advance;
    logic        fetch_err;
    logic        align_fault;

    int checks = 0;
    int errors = 0;

    fetch_unit_if #(.ADDR_W(32), .INSTR_W(32)) bus ();

    fetch_unit #(.ADDR_W(32), .INSTR_W(32), .TIMEOUT_CYCLES(15)) dut (
        .clock       (clock),
        .reset       (reset),
        .fetch_en    (fetch_en),
        .pc          (pc),
        .flush       (flush),
        .imem        (bus),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .id_ready    (id_ready),
        .pc_advance  (pc_advance),
        .fetch_err   (fetch_err),
        .align_fault (align_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; fetch_en = 1'b0; pc = 32'h0; flush = 1'b0; id_ready = 1'b0;
        bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0;
        step(); step();
        chk("rst_req",   {31'b0, bus.imem_req}, 32'd0);
        chk("rst_addr",  bus.imem_addr, 32'h0);
        chk("rst_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_instr", if_instr, 32'h0);
        chk("rst_ifpc",  if_pc, 32'h0);
        chk("rst_adv",   {31'b0, pc_advance}, 32'd0);
        chk("rst_err",   {31'b0, fetch_err}, 32'd0);
        chk("rst_align", {31'b0, align_fault}, 32'd0);
        reset = 1'b0;
        step();

        // Zero-wait fetch with immediate decode accept
        fetch_en = 1'b1; pc = 32'h100; id_ready = 1'b1;
        step();
        chk("t1_req",  {31'b0, bus.imem_req}, 32'd1);
        chk("t1_addr", bus.imem_addr, 32'h100);
        chk("t1_valid_early", {31'b0, if_valid}, 32'd0);
        fetch_en = 1'b0; bus.imem_ack = 1'b1; bus.imem_rdata = 32'h8B020020;
        step();
        chk("t1_valid", {31'b0, if_valid}, 32'd1);
        chk("t1_instr", if_instr, 32'h8B020020);
        chk("t1_ifpc",  if_pc, 32'h100);
        chk("t1_req_drop", {31'b0, bus.imem_req}, 32'd0);
        chk("t1_adv_hold", {31'b0, pc_advance}, 32'd0);
        bus.imem_ack = 1'b0;
        step();
        chk("t1_adv", {31'b0, pc_advance}, 32'd1);
        chk("t1_valid_clr", {31'b0, if_valid}, 32'd0);
        id_ready = 1'b0;
        step();
        chk("t1_adv_pulse", {31'b0, pc_advance}, 32'd0);

        // Decode stall in HOLD
        fetch_en = 1'b1; pc = 32'h104;
        step();
        fetch_en = 1'b0; bus.imem_ack = 1'b1; bus.imem_rdata = 32'h12345678;
        step();
        bus.imem_ack = 1'b0; bus.imem_rdata = 32'hFFFFFFFF;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t2_valid", {31'b0, if_valid}, 32'd1);
            chk("t2_instr", if_instr, 32'h12345678);
            chk("t2_ifpc",  if_pc, 32'h104);
            chk("t2_noadv", {31'b0, pc_advance}, 32'd0);
        end
        id_ready = 1'b1;
        step();
        chk("t2_adv", {31'b0, pc_advance}, 32'd1);
        chk("t2_valid_clr", {31'b0, if_valid}, 32'd0);
        id_ready = 1'b0;
        step();
        chk("t2_adv_pulse", {31'b0, pc_advance}, 32'd0);

        // Flush during REQ, late ack drains and is discarded
        fetch_en = 1'b1; pc = 32'h120;
        step();
        chk("t3_req", {31'b0, bus.imem_req}, 32'd1);
        fetch_en = 1'b0; flush = 1'b1;
        step();
        chk("t3_drain_req", {31'b0, bus.imem_req}, 32'd1);
        flush = 1'b0;
        step();
        chk("t3_drain_req2", {31'b0, bus.imem_req}, 32'd1);
        step();
        chk("t3_drain_req3", {31'b0, bus.imem_req}, 32'd1);
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEADBEEF;
        step();
        chk("t3_req_drop", {31'b0, bus.imem_req}, 32'd0);
        chk("t3_novalid",  {31'b0, if_valid}, 32'd0);
        bus.imem_ack = 1'b0;
        fetch_en = 1'b1; pc = 32'h140;
        step();
        chk("t3_req2",  {31'b0, bus.imem_req}, 32'd1);
        chk("t3_addr2", bus.imem_addr, 32'h140);
        fetch_en = 1'b0; bus.imem_ack = 1'b1; bus.imem_rdata = 32'h00A00093;
        step();
        chk("t3_valid2", {31'b0, if_valid}, 32'd1);
        chk("t3_ifpc2",  if_pc, 32'h140);
        chk("t3_instr2", if_instr, 32'h00A00093);
        bus.imem_ack = 1'b0; id_ready = 1'b1;
        step();
        chk("t3_adv2", {31'b0, pc_advance}, 32'd1);
        id_ready = 1'b0;
        step();

        // Flush coincident with ack
        fetch_en = 1'b1; pc = 32'h200;
        step();
        fetch_en = 1'b0; bus.imem_ack = 1'b1; bus.imem_rdata = 32'h55555555; flush = 1'b1;
        step();
        chk("t4a_req",   {31'b0, bus.imem_req}, 32'd0);
        chk("t4a_valid", {31'b0, if_valid}, 32'd0);
        bus.imem_ack = 1'b0; flush = 1'b0;
        step();
        chk("t4a_valid2", {31'b0, if_valid}, 32'd0);
        chk("t4a_req2",   {31'b0, bus.imem_req}, 32'd0);

        // Flush coincident with id_ready in HOLD
        fetch_en = 1'b1; pc = 32'h204;
        step();
        fetch_en = 1'b0; bus.imem_ack = 1'b1; bus.imem_rdata = 32'h11111111;
        step();
        chk("t4b_valid", {31'b0, if_valid}, 32'd1);
        bus.imem_ack = 1'b0; flush = 1'b1; id_ready = 1'b1;
        step();
        chk("t4b_valid_clr", {31'b0, if_valid}, 32'd0);
        chk("t4b_noadv",     {31'b0, pc_advance}, 32'd0);
        flush = 1'b0; id_ready = 1'b0;
        step();
        chk("t4b_noadv2", {31'b0, pc_advance}, 32'd0);

        // Timeout: request high for exactly 15 cycles, then sticky error
        fetch_en = 1'b1; pc = 32'h300;
        step();
        chk("t5_req_start", {31'b0, bus.imem_req}, 32'd1);
        for (int i = 1; i < 15; i++) begin
            step();
            chk("t5_req_wait", {31'b0, bus.imem_req}, 32'd1);
            chk("t5_err_wait", {31'b0, fetch_err}, 32'd0);
        end
        step();
        chk("t5_err", {31'b0, fetch_err}, 32'd1);
        chk("t5_req_drop", {31'b0, bus.imem_req}, 32'd0);
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h77777777;
        step();
        chk("t5_late_ack", {31'b0, if_valid}, 32'd0);
        bus.imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_blocked", {31'b0, bus.imem_req}, 32'd0);
            chk("t5_sticky",  {31'b0, fetch_err}, 32'd1);
        end
        reset = 1'b1;
        step();
        chk("t5_err_clr", {31'b0, fetch_err}, 32'd0);
        reset = 1'b0; fetch_en = 1'b0;
        step();

        // Misaligned PC
        fetch_en = 1'b1; pc = 32'h102;
        step();
        chk("t6_align", {31'b0, align_fault}, 32'd1);
        chk("t6_noreq", {31'b0, bus.imem_req}, 32'd0);
        pc = 32'h108;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_noreq2", {31'b0, bus.imem_req}, 32'd0);
            chk("t6_sticky", {31'b0, align_fault}, 32'd1);
        end

        // Reset mid-transaction drops the request immediately
        reset = 1'b1;
        step();
        reset = 1'b0; pc = 32'h400;
        step();
        chk("t7_req", {31'b0, bus.imem_req}, 32'd1);
        chk("t7_align_clr", {31'b0, align_fault}, 32'd0);
        fetch_en = 1'b0; reset = 1'b1;
        step();
        chk("t7_req_drop", {31'b0, bus.imem_req}, 32'd0);
        reset = 1'b0;
        step();
        chk("t7_idle", {31'b0, bus.imem_req}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
